// File: rtl/pm_access_arbiter.sv
// Arbitrates the single program memory between the processor fetch path and a host loader port.
// The processor is stalled and fed NOP_INSTR for every cycle the host owns the memory.
module pm_access_arbiter #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] NOP_INSTR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_pm_address,
    output logic [DATA_W-1:0] cpu_pm_data,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_CPU    = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   in_access;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_CPU;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rdata <= '0;
        end else if (state == S_ACCESS && !host_we) begin
            host_rdata <= mem_rdata;
        end
    end

    // NOTE: state_next gets a default before the case so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_CPU:    if (host_req) state_next = S_ACCESS;
            S_ACCESS: state_next = S_ACK;
            S_ACK:    state_next = host_req ? S_ACCESS : S_CPU;
            default:  state_next = S_CPU;
        endcase
    end

    // Memory and stall controls decode from the state register only; host_req never reaches the memory.
    assign in_access   = (state == S_ACCESS);
    assign mem_addr    = in_access ? host_addr : cpu_pm_address;
    assign mem_wdata   = host_wdata;
    assign mem_we      = in_access & host_we;
    assign cpu_stall   = in_access | host_lock;
    assign cpu_pm_data = cpu_stall ? NOP_INSTR : mem_rdata;
    assign host_ack    = (state == S_ACK);

endmodule

// File: tb/tb_pm_access_arbiter.sv
// Self-checking bench for pm_access_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level transaction model and a shadow copy of program memory.
module tb_pm_access_arbiter;

    localparam logic [7:0] NOP = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cpu_pm_address = '0;
    logic [7:0] cpu_pm_data;
    logic       cpu_stall;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_lock = 1'b0;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    pm_access_arbiter #(.ADDR_W(8), .DATA_W(8), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .cpu_pm_address(cpu_pm_address), .cpu_pm_data(cpu_pm_data), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Program memory attached to the arbiter
    logic [7:0] tb_mem [256];
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

    // Reference model: what the memory should contain and what the host should see this cycle
    logic [7:0] ref_mem [256];
    logic       m_access = 1'b0;
    logic       m_ack = 1'b0;
    logic [7:0] m_rdata = '0;

    // Inputs applied during the current cycle
    logic       cur_reset = 1'b0, cur_req = 1'b0, cur_we = 1'b0, cur_lock = 1'b0;
    logic [7:0] cur_addr = '0, cur_wdata = '0, cur_cpu = '0;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    endtask

    // A host transaction occupies the cycle after its request is taken, and is acknowledged the cycle after that.
    task automatic model_edge();
        logic take;
        if (!cur_reset) begin
            m_access = 1'b0;
            m_ack    = 1'b0;
            m_rdata  = '0;
        end else begin
            if (m_access) begin
                if (cur_we) ref_mem[cur_addr] = cur_wdata;
                else        m_rdata = ref_mem[cur_addr];
            end
            take     = cur_req && !m_access;
            m_ack    = m_access;
            m_access = take;
        end
    endtask

    task automatic check_all();
        logic stall_exp;
        stall_exp = m_access | cur_lock;
        check("mem_we",    {31'b0, mem_we},    {31'b0, m_access & cur_we});
        check("mem_addr",  {24'b0, mem_addr},  {24'b0, m_access ? cur_addr : cur_cpu});
        check("cpu_stall", {31'b0, cpu_stall}, {31'b0, stall_exp});
        check("pm_data",   {24'b0, cpu_pm_data}, {24'b0, stall_exp ? NOP : ref_mem[cur_cpu]});
        check("host_ack",  {31'b0, host_ack},  {31'b0, m_ack});
        check("host_rdata",{24'b0, host_rdata}, {24'b0, m_rdata});
        if (m_access && cur_we) check("mem_wdata", {24'b0, mem_wdata}, {24'b0, cur_wdata});
    endtask

    task automatic step(input logic rst, input logic req, input logic we, input logic lock,
                        input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] cpu);
        @(posedge clk);
        model_edge();
        #1;
        reset = rst;          cur_reset = rst;
        host_req = req;       cur_req = req;
        host_we = we;         cur_we = we;
        host_lock = lock;     cur_lock = lock;
        host_addr = addr;     cur_addr = addr;
        host_wdata = wdata;   cur_wdata = wdata;
        cpu_pm_address = cpu; cur_cpu = cpu;
        #1;
        check_all();
    endtask

    // Request, access and acknowledge cycles of one isolated transaction; returns stalled-cycle count.
    task automatic txn(input logic we, input logic lock, input logic [7:0] addr,
                       input logic [7:0] wdata, output int stalls);
        stalls = 0;
        step(1, 1, we, lock, addr, wdata, cur_cpu);
        stalls += int'(cpu_stall);
        step(1, 0, we, lock, addr, wdata, cur_cpu);
        stalls += int'(cpu_stall);
        step(1, 0, we, lock, addr, wdata, cur_cpu);
        stalls += int'(cpu_stall);
    endtask

    initial begin
        int stalls;
        int acks;
        int bad;
        logic [7:0] r_addr, r_wdata;
        logic r_we;

        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end

        // Reset held with a pending request
        #2 check_all();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h10, 8'h00, 8'h40);
        step(1, 1, 0, 0, 8'h10, 8'h00, 8'h40);
        step(1, 0, 0, 0, 8'h10, 8'h00, 8'h40);
        check("rst_release_access", {31'b0, cpu_stall}, 32'd1);
        step(1, 0, 0, 0, 8'h10, 8'h00, 8'h40);
        step(1, 0, 0, 0, 8'h10, 8'h00, 8'h40);

        // Single write then read-back
        txn(1, 0, 8'h10, 8'hA5, stalls);
        check("wr_stall_cycles", stalls, 32'd1);
        txn(0, 0, 8'h10, 8'h00, stalls);
        check("rd_a5", {24'b0, host_rdata}, 32'hA5);
        check("rd_stall_cycles", stalls, 32'd1);
        step(1, 0, 0, 0, 8'h10, 8'h00, 8'h41);

        // Back-to-back reads of 0..3 with host_req held high
        acks = 0;
        step(1, 1, 0, 0, 8'h00, 8'h00, 8'h42);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 8'(i), 8'h00, 8'h42);
            check("b2b_nop", {24'b0, cpu_pm_data}, {24'b0, NOP});
            step(1, i < 3, 0, 0, 8'(i + 1), 8'h00, 8'h42);
            acks += int'(host_ack);
            check("b2b_rdata", {24'b0, host_rdata}, {24'b0, tb_mem[i]});
        end
        check("b2b_acks", acks, 32'd4);
        step(1, 0, 0, 0, 8'h00, 8'h00, 8'h42);

        // Processor runs alone
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step(1, 0, 0, 0, 8'h00, 8'h00, 8'($urandom));
            if (cpu_stall !== 1'b0 || mem_addr !== cur_cpu) bad++;
        end
        check("cpu_run_clean", bad, 32'd0);

        // Download under host_lock
        bad = 0;
        step(1, 0, 0, 1, 8'h00, 8'h00, 8'h77);
        step(1, 1, 1, 1, 8'h00, 8'h30, 8'h77);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 1, 1, 8'(i), 8'(8'h30 + i), 8'h77);
            if (cpu_stall !== 1'b1 || cpu_pm_data !== NOP) bad++;
            step(1, i < 15, 1, 1, 8'(i + 1), 8'(8'h31 + i), 8'h77);
            if (cpu_stall !== 1'b1 || cpu_pm_data !== NOP) bad++;
        end
        step(1, 0, 0, 1, 8'h00, 8'h00, 8'h77);
        check("lock_stalled", bad, 32'd0);
        step(1, 0, 0, 0, 8'h00, 8'h00, 8'h77);
        check("lock_release_stall", {31'b0, cpu_stall}, 32'd0);
        check("lock_release_addr", {24'b0, mem_addr}, 32'h77);
        check("download_word", {24'b0, tb_mem[8'h0B]}, 32'h3B);

        // Reset asserted in the middle of a write access
        txn(1, 0, 8'h20, 8'h11, stalls);
        step(1, 0, 0, 0, 8'h20, 8'h00, 8'h50);
        step(1, 1, 1, 0, 8'h20, 8'h5A, 8'h50);
        step(1, 0, 1, 0, 8'h20, 8'h5A, 8'h50);
        check("mid_rst_we_before", {31'b0, mem_we}, 32'd1);
        #1;
        reset = 1'b0; cur_reset = 1'b0;
        m_access = 1'b0; m_ack = 1'b0; m_rdata = '0;
        #1;
        check("mid_rst_we_drop", {31'b0, mem_we}, 32'd0);
        check_all();
        step(0, 0, 1, 0, 8'h20, 8'h5A, 8'h50);
        step(0, 0, 0, 0, 8'h20, 8'h00, 8'h50);
        step(1, 0, 0, 0, 8'h20, 8'h00, 8'h50);
        txn(0, 0, 8'h20, 8'h00, stalls);
        check("mid_rst_kept", {24'b0, host_rdata}, 32'h11);
        step(1, 0, 0, 0, 8'h20, 8'h00, 8'h50);

        // Randomized traffic; transaction fields stay stable from request through access
        r_addr = '0; r_wdata = '0; r_we = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!(cur_req && !m_access)) begin
                r_addr  = 8'($urandom);
                r_wdata = 8'($urandom);
                r_we    = 1'($urandom);
            end
            step(1, 1'($urandom), r_we, ($urandom_range(0, 9) == 0),
                 r_addr, r_wdata, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
